// File: rtl/seg_output_display.sv
// rtl/seg_output_display.sv - debounced 16-bit value on a 4-digit multiplexed 7-segment display (option: SEG_OUTPUT_DISPLAY_BLANK_EN)
module seg_output_display #(
    parameter int REFRESH_DIV   = 100000,
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] data_in,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        dp,
    output logic [15:0] shown,
    output logic        upd
);

    localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [PW-1:0] PRESC_MAX  = PW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] STABLE_MAX = CW'(STABLE_CYCLES);

    logic [15:0]   in_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   shown_q, shown_d;
    logic          upd_q, upd_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    digit_q, digit_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;
    logic [3:0]    nibble;
    logic          blank;

    // Active-low hex glyph, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    // Stability filter: a value is accepted only after it has been sampled unchanged long enough.
    always_comb begin
        cnt_d   = cnt_q;
        shown_d = shown_q;
        upd_d   = 1'b0;
        if (data_in != in_q) begin
            cnt_d = '0;
        end else if (cnt_q != STABLE_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
        if ((cnt_q == STABLE_MAX) && (in_q != shown_q)) begin
            shown_d = in_q;
            upd_d   = 1'b1;
        end
    end

    // Scan timing: prescaler wrap steps to the next digit slot.
    always_comb begin
        presc_d = presc_q + 1'b1;
        digit_d = digit_q;
        if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            digit_d = digit_q + 2'd1;
        end
    end

    // Leading-zero blanking: digits above the top nonzero nibble stay dark; digit 0 always lit.
    always_comb begin
        blank = 1'b0;
`ifdef SEG_OUTPUT_DISPLAY_BLANK_EN
        begin
            logic [1:0] top;
            top = 2'd0;
            for (int i = 1; i < 4; i++) begin
                if (shown_q[4*i +: 4] != 4'h0) top = 2'(i);
            end
            blank = (digit_q > top);
        end
`endif
    end

    // Drive for the current slot; registered so seg/an lag digit index and shown by one cycle.
    always_comb begin
        nibble = shown_q[{digit_q, 2'b00} +: 4];
        seg_d  = 7'b1111111;
        an_d   = 4'b1111;
        if (!blank) begin
            seg_d = hex7(nibble);
            an_d  = ~(4'b0001 << digit_q);
        end
    end

    // Input sampling and accepted-value state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q    <= '0;
            cnt_q   <= '0;
            shown_q <= '0;
            upd_q   <= 1'b0;
        end else begin
            in_q    <= data_in;
            cnt_q   <= cnt_d;
            shown_q <= shown_d;
            upd_q   <= upd_d;
        end
    end

    // Scan counters and registered display drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            digit_q <= '0;
            seg_q   <= 7'b1111111;
            an_q    <= 4'b1111;
        end else begin
            presc_q <= presc_d;
            digit_q <= digit_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign seg   = seg_q;
    assign an    = an_q;
    assign dp    = 1'b1;
    assign shown = shown_q;
    assign upd   = upd_q;

endmodule

// File: tb/tb_seg_output_display.sv
// tb/tb_seg_output_display.sv - directed self-checking bench for seg_output_display
module tb_seg_output_display;

    logic        clk;
    logic        rst_n;
    logic [15:0] data_in;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp;
    logic [15:0] shown;
    logic        upd;

    int vec_cnt = 0;
    int err_cnt = 0;

    seg_output_display #(.REFRESH_DIV(4), .STABLE_CYCLES(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_in (data_in),
        .seg     (seg),
        .an      (an),
        .dp      (dp),
        .shown   (shown),
        .upd     (upd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Wait (bounded) for the first cycle of digit slot 0, sampled at negedge.
    task automatic find_slot0(output bit found);
        logic [3:0] prev;
        found = 1'b0;
        prev  = an;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (an == 4'b1110 && prev != 4'b1110) found = 1'b1;
            prev = an;
        end
        check("slot0_found", {31'd0, found}, 32'd1);
    endtask

    // Check four slots of four cycles each against expected an/seg per slot.
    task automatic check_scan(input string tag, input logic [3:0] an_e [4], input logic [6:0] seg_e [4]);
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 4; c++) begin
                if (s != 0 || c != 0) tick();
                check({tag, "_an"}, {28'd0, an}, {28'd0, an_e[s]});
                check({tag, "_seg"}, {25'd0, seg}, {25'd0, seg_e[s]});
                check({tag, "_dp"}, {31'd0, dp}, 32'd1);
            end
        end
    endtask

    initial begin
        logic [3:0] an_e [4];
        logic [6:0] seg_e [4];
        bit found;

        rst_n   = 1'b0;
        data_in = 16'h0000;
        #12;
        check("rst_an", {28'd0, an}, 32'hF);
        check("rst_seg", {25'd0, seg}, 32'h7F);
        check("rst_dp", {31'd0, dp}, 32'd1);
        check("rst_shown", {16'd0, shown}, 32'h0);
        check("rst_upd", {31'd0, upd}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();

        // Acceptance latency: change before edge 0, accepted on edge 5.
        data_in = 16'h12AB;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("acc_shown_early", {16'd0, shown}, 32'h0);
            check("acc_upd_early", {31'd0, upd}, 32'd0);
        end
        tick();
        check("acc_shown", {16'd0, shown}, 32'h12AB);
        check("acc_upd", {31'd0, upd}, 32'd1);
        tick();
        check("acc_upd_single", {31'd0, upd}, 32'd0);

        // One-cycle glitch back to 0000 must not disturb shown.
        data_in = 16'h0000;
        tick();
        data_in = 16'h12AB;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("rehold_upd", {31'd0, upd}, 32'd0);
        end
        check("rehold_shown", {16'd0, shown}, 32'h12AB);

        // Scan order and glyphs for 12AB.
        an_e  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        seg_e = '{7'b0000011, 7'b0001000, 7'b0100100, 7'b1111001};
        find_slot0(found);
        if (found) check_scan("scan", an_e, seg_e);

        // Asynchronous reset between edges, mid-scan.
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_an", {28'd0, an}, 32'hF);
        check("arst_seg", {25'd0, seg}, 32'h7F);
        check("arst_shown", {16'd0, shown}, 32'h0);
        check("arst_upd", {31'd0, upd}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check("arst_rel_upd", {31'd0, upd}, 32'd0);

        // Glitch of FFFF held only three samples.
        data_in = 16'hFFFF;
        repeat (3) tick();
        data_in = 16'h0000;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("glitch_upd", {31'd0, upd}, 32'd0);
            check("glitch_shown", {16'd0, shown}, 32'h0);
        end

        // Leading-zero handling for 0005.
        data_in = 16'h0005;
        repeat (7) tick();
        check("blank_shown", {16'd0, shown}, 32'h0005);
`ifdef SEG_OUTPUT_DISPLAY_BLANK_EN
        an_e  = '{4'b1110, 4'b1111, 4'b1111, 4'b1111};
        seg_e = '{7'b0010010, 7'b1111111, 7'b1111111, 7'b1111111};
`else
        an_e  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        seg_e = '{7'b0010010, 7'b1000000, 7'b1000000, 7'b1000000};
`endif
        find_slot0(found);
        if (found) check_scan("blank", an_e, seg_e);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/seg_output_display.md
SEG_OUTPUT_DISPLAY -- requirements
Module: seg_output_display

Interface
REQ-001 Parameter: REFRESH_DIV, 100000, clk cycles per digit slot; legal range >= 2.
REQ-002 Parameter: STABLE_CYCLES, 4, consecutive equal samples required before data_in is accepted; legal range >= 1.
REQ-003 Port: clk  input  1  single system clock; all state on rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: data_in  input  16  processor result bus (the processor's out), unqualified and may glitch.
REQ-006 Port: seg  output  7  registered segment drive {g,f,e,d,c,b,a}, active-low.
REQ-007 Port: an  output  4  registered digit enables, active-low; an[0] = least significant nibble.
REQ-008 Port: dp  output  1  decimal point, active-low; held 1 (off) always.
REQ-009 Port: shown  output  16  value currently accepted for display.
REQ-010 Port: upd  output  1  one-cycle pulse on the edge shown takes a new value.

Function
REQ-011 Sample register in_q SHALL capture data_in on every rising edge.
REQ-012 Stability counter SHALL clear to 0 on any edge where data_in != in_q, else increment, saturating at STABLE_CYCLES.
REQ-013 On an edge where counter == STABLE_CYCLES and in_q != shown, shown SHALL load in_q and upd SHALL be 1 for that cycle only.
REQ-014 Latency: data_in changing before edge 0 and held constant SHALL appear on shown at edge STABLE_CYCLES+1 (STABLE_CYCLES+2 edges total).
REQ-015 A stable value equal to shown SHALL produce no upd pulse.
REQ-016 A change held for fewer than STABLE_CYCLES+1 samples SHALL NOT alter shown.
REQ-017 Prescaler SHALL count 0..REFRESH_DIV-1 and wrap; on the wrap edge, digit index SHALL advance 0->1->2->3->0.
REQ-018 seg/an SHALL be registered from the current digit index and shown, one cycle behind them; exactly one an bit low per slot, except under blanking (REQ-026).
REQ-019 Hex encoding (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-020 A shown update mid-slot SHALL be reflected on seg the following cycle without restarting the prescaler or digit index.

Reset
REQ-021 rst_n low SHALL immediately, independent of clk, force: in_q=0, counter=0, shown=0, upd=0, prescaler=0, digit index=0, seg=1111111, an=1111, dp=1.
REQ-022 Reset asserted mid-scan or mid-stability-count SHALL abandon the operation; no upd pulse SHALL occur during or on release of reset.
REQ-023 After rst_n release, first scan SHALL start at digit 0 on the first edge; data_in acceptance restarts per REQ-012.

Configuration
REQ-024 Macro SEG_OUTPUT_DISPLAY_BLANK_EN SHALL select leading-zero blanking.
REQ-025 Without the macro, all four digits SHALL be driven every scan, leading zeros shown as 1000000.
REQ-026 With the macro, any digit above the most significant nonzero nibble of shown SHALL keep its an bit at 1 for its slot (all an=1111, seg=1111111); digit 0 SHALL never be blanked; slot timing unchanged.

Verification
REQ-027 Reset: assert rst_n low between clock edges mid-scan -> an=1111, seg=1111111, shown=0000, upd=0 before the next edge.
REQ-028 Acceptance: STABLE_CYCLES=4, data_in 0000->12AB held -> shown=12AB and upd high exactly at edge 5 (6th edge), single cycle.
REQ-029 Glitch: data_in=FFFF for 3 cycles then 0000 -> shown stays 0000, upd never asserts.
REQ-030 Scan: REFRESH_DIV=4, shown=12AB -> an sequence 1110,1101,1011,0111 each for 4 cycles; seg 0000011, 0001000, 0100100, 1111001 respectively.
REQ-031 Blanking: shown=0005 -> with macro an=1110/seg=0010010 in slot 0, an=1111 in slots 1-3; without macro slots 1-3 show seg=1000000.
REQ-032 Re-hold: after shown=12AB, data_in glitches to 0000 for 1 cycle then back to 12AB -> no upd pulse, shown unchanged.
